// File: rtl/eeprom_i2c_master.sv
// eeprom_i2c_master: I2C master issuing byte-write and random-read transactions to a 2K x 8 serial EEPROM
//
// Parameters:
//   CLK_DIV    clk cycles per quarter SCL period (2..1023); SCL period = 4*CLK_DIV clks
// Ports:
//   clk_i      system clock, all logic on the rising edge
//   reset_i    synchronous active-high reset
//   wr_req_i   start a byte write when idle (write wins if both requests are high)
//   rd_req_i   start a random read when idle
//   addr_i     EEPROM address: [10:8] page bits in the control byte, [7:0] address byte
//   wdata_i    write data, captured on acceptance
//   rdata_o    read data, valid from the done pulse until the next accepted read
//   busy_o     high from acceptance until the done pulse
//   done_o     one-clk pulse when IDLE is re-entered
//   ack_err_o  sticky NACK flag, cleared on the next acceptance
//   scl_o      I2C clock, push-pull
//   sda_io     I2C data, open-drain (drives 0 or z only)
// Build option:
//   EEPROM_I2C_ACK_CHECK_EN  sample slave ACK slots; a NACK sets ack_err_o and jumps to STOP.
//                            Without it ACK slots are clocked but ignored and ack_err_o is 0.
module eeprom_i2c_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_req_i,
    input  logic        rd_req_i,
    input  logic [10:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic [7:0]  rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ack_err_o,
    output logic        scl_o,
    inout  wire         sda_io
);
    typedef enum logic [3:0] {
        IDLE, START, CTRL_W, ACK1, ADDR, ACK2, WDATA, ACK3,
        RSTART, CTRL_R, ACK4, RDATA, MNACK, STOP
    } state_t;

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [1:0]  ph_q;
    logic [2:0]  cnt_q;
    logic [9:0]  div_q;
    logic        busy_q, done_q, rd_q;
    logic [10:0] addr_q;
    logic [7:0]  wdata_q, rx_q, rdata_q, tx_byte;
    logic        scl_q, scl_d, sda_rel_q, sda_rel_d;
    logic [1:0]  sda_s_q;
    logic        tick, sample, slot_end, byte_end, stop_end, req, accept, byte_st, ack_st;
    logic        sda_in, clk_hi, nack;

    assign req      = wr_req_i | rd_req_i;
    assign accept   = (state_q == IDLE) && req;
    assign tick     = busy_q && (div_q == DIV_LAST);
    // Sample at the end of P2, after SCL has been high for two quarter periods.
    assign sample   = tick && (ph_q == 2'd2);
    assign slot_end = tick && (ph_q == 2'd3);
    assign byte_st  = state_q inside {CTRL_W, ADDR, WDATA, CTRL_R, RDATA};
    assign ack_st   = state_q inside {ACK1, ACK2, ACK3, ACK4};
    assign byte_end = slot_end && (cnt_q == 3'd0);
    assign stop_end = slot_end && (state_q == STOP);
    assign sda_in   = sda_s_q[1];
    // SCL is high during P1 and P2 of a normal bit slot.
    assign clk_hi   = ph_q[0] ^ ph_q[1];

    assign tx_byte = (state_q == CTRL_W) ? {4'b1010, addr_q[10:8], 1'b0} :
                     (state_q == CTRL_R) ? {4'b1010, addr_q[10:8], 1'b1} :
                     (state_q == ADDR)   ? addr_q[7:0] : wdata_q;

`ifdef EEPROM_I2C_ACK_CHECK_EN
    logic ack_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_err_q <= 1'b0;
        end else if (accept) begin
            ack_err_q <= 1'b0;
        end else if (sample && ack_st && sda_in) begin
            ack_err_q <= 1'b1;
        end
    end

    assign nack = ack_err_q;
`else
    assign nack = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req ? START : IDLE;
            START:   state_d = slot_end ? CTRL_W : START;
            CTRL_W:  state_d = byte_end ? ACK1 : CTRL_W;
            ACK1:    state_d = slot_end ? (nack ? STOP : ADDR) : ACK1;
            ADDR:    state_d = byte_end ? ACK2 : ADDR;
            ACK2:    state_d = slot_end ? (nack ? STOP : (rd_q ? RSTART : WDATA)) : ACK2;
            WDATA:   state_d = byte_end ? ACK3 : WDATA;
            ACK3:    state_d = slot_end ? STOP : ACK3;
            RSTART:  state_d = slot_end ? CTRL_R : RSTART;
            CTRL_R:  state_d = byte_end ? ACK4 : CTRL_R;
            ACK4:    state_d = slot_end ? (nack ? STOP : RDATA) : ACK4;
            RDATA:   state_d = byte_end ? MNACK : RDATA;
            MNACK:   state_d = slot_end ? STOP : MNACK;
            STOP:    state_d = slot_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Pin levels per state and phase; registered below so the pins never glitch.
    always_comb begin
        scl_d     = clk_hi;
        sda_rel_d = 1'b1;
        case (state_q)
            IDLE: begin
                scl_d     = 1'b1;
                sda_rel_d = 1'b1;
            end
            START: begin
                scl_d     = (ph_q != 2'd3);
                sda_rel_d = ~ph_q[1];
            end
            RSTART: begin
                scl_d     = clk_hi;
                sda_rel_d = ~ph_q[1];
            end
            STOP: begin
                scl_d     = (ph_q != 2'd0);
                sda_rel_d = (ph_q == 2'd3);
            end
            CTRL_W, ADDR, WDATA, CTRL_R: begin
                scl_d     = clk_hi;
                sda_rel_d = tx_byte[cnt_q];
            end
            default: begin
                scl_d     = clk_hi;
                sda_rel_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ph_q      <= 2'd0;
            cnt_q     <= 3'd0;
            div_q     <= 10'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 11'd0;
            wdata_q   <= 8'd0;
            rx_q      <= 8'd0;
            rdata_q   <= 8'd0;
            scl_q     <= 1'b1;
            sda_rel_q <= 1'b1;
            sda_s_q   <= 2'b11;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_rel_q <= sda_rel_d;
            sda_s_q   <= {sda_s_q[0], sda_io};
            done_q    <= stop_end;
            div_q     <= (busy_q && !tick) ? div_q + 10'd1 : 10'd0;
            if (tick) ph_q <= ph_q + 2'd1;
            // Counter wraps 0 -> 7 when a byte finishes, ready for the next byte.
            if (slot_end && byte_st) cnt_q <= cnt_q - 3'd1;
            if (sample && state_q == RDATA) rx_q <= {rx_q[6:0], sda_in};
            if (accept) begin
                busy_q  <= 1'b1;
                rd_q    <= ~wr_req_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                cnt_q   <= 3'd7;
                ph_q    <= 2'd0;
            end
            if (stop_end) begin
                busy_q <= 1'b0;
                if (rd_q && !nack) rdata_q <= rx_q;
            end
        end
    end

    assign sda_io    = sda_rel_q ? 1'bz : 1'b0;
    assign scl_o     = scl_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign ack_err_o = nack;
endmodule

// File: tb/tb_eeprom_i2c_master.sv
// tb_eeprom_i2c_master: directed table-driven bench with a behavioural EEPROM slave on the I2C bus
module tb_eeprom_i2c_master;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [10:0] addr = 11'd0;
    logic [7:0]  wdata = 8'd0;
    logic [7:0]  rdata;
    logic        busy, done, ack_err, scl;
    wire         sda;
    logic        sl_drv = 1'b0;
    bit          sl_en = 1'b1;

    assign sda = sl_drv ? 1'b0 : 1'bz;
    pullup (sda);

    eeprom_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i(clk), .reset_i(reset), .wr_req_i(wr_req), .rd_req_i(rd_req),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy),
        .done_o(done), .ack_err_o(ack_err), .scl_o(scl), .sda_io(sda)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_rd = 8'd0;
    logic [7:0]  mem [2048];
    int          log_q[$];

    // Slave + bus monitor: log entries are -1 START, -2 STOP, else {byte, ack bit}.
    initial begin
        logic       scl_p, sda_p, tx_mode, ack_p, rw;
        int         bitn, byte_n;
        logic [8:0] sh;
        logic [2:0] page;
        logic [10:0] ptr;
        logic [7:0] txb;
        scl_p = 1'b1; sda_p = 1'b1; tx_mode = 1'b0; ack_p = 1'b0; rw = 1'b0;
        bitn = 0; byte_n = 0; sh = 9'd0; page = 3'd0; ptr = 11'd0; txb = 8'd0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
        forever begin
            @(scl or sda);
            if (scl_p === 1'b1 && scl === 1'b1 && sda_p === 1'b1 && sda === 1'b0) begin
                log_q.push_back(-1);
                bitn = 0; byte_n = 0; tx_mode = 1'b0; ack_p = 1'b0; sl_drv = 1'b0;
            end else if (scl_p === 1'b1 && scl === 1'b1 && sda_p === 1'b0 && sda === 1'b1) begin
                log_q.push_back(-2);
                bitn = 0; byte_n = 0; tx_mode = 1'b0; ack_p = 1'b0; sl_drv = 1'b0;
            end else if (scl_p === 1'b0 && scl === 1'b1) begin
                sh = {sh[7:0], sda};
                bitn++;
                if (bitn == 8 && !tx_mode) begin
                    ack_p = sl_en && (byte_n != 0 || sh[7:4] == 4'b1010);
                    if (byte_n == 0) begin
                        page = sh[3:1];
                        rw = sh[0];
                    end else if (byte_n == 1) begin
                        ptr = {page, sh[7:0]};
                    end else if (byte_n == 2 && ack_p) begin
                        mem[ptr] = sh[7:0];
                    end
                end
                if (bitn == 9) begin
                    log_q.push_back(int'(sh));
                    bitn = 0;
                    tx_mode = !tx_mode && byte_n == 0 && rw && ack_p;
                    if (tx_mode) txb = mem[ptr];
                    byte_n++;
                end
            end else if (scl_p === 1'b1 && scl === 1'b0) begin
                sl_drv = (tx_mode && bitn < 8) ? !txb[7 - bitn] : (!tx_mode && bitn == 8 && ack_p);
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic accept_req(input bit rd, input bit wr, input logic [10:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_req = wr; rd_req = rd; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    // Runs one transaction and checks timing, flags, rdata, bus log and slave memory.
    task automatic txn(input string nm, input bit rd, input logic [10:0] a, input logic [7:0] d,
                       input logic [7:0] rdv, input bit nack, input bit acked, input int ecyc);
        int  cyc;
        bit  ok;
        int  e[$];
        bit  ab;
        log_q.delete();
        accept_req(rd, !rd, a, d);
        chk({nm, " busy_at_accept"}, int'(busy), 1);
        chk({nm, " ack_err_cleared"}, int'(ack_err), 0);
        cyc = 0; ok = 1'b0;
        while (cyc < 3000 && !ok) begin
            @(posedge clk); #1;
            cyc++;
            ok = (done === 1'b1);
        end
        chk({nm, " done_seen"}, int'(ok), 1);
        chk({nm, " cycles"}, cyc, ecyc);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        if (rd && !nack) exp_rd = rdv;
        chk({nm, " rdata"}, int'(rdata), int'(exp_rd));
        chk({nm, " ack_err"}, int'(ack_err), int'(nack));
        @(posedge clk); #1;
        chk({nm, " done_width"}, int'(done), 0);
        ab = !acked;
        e.push_back(-1);
        e.push_back(int'({4'b1010, a[10:8], 1'b0, ab}));
        if (!nack) begin
            e.push_back(int'({a[7:0], ab}));
            if (rd) begin
                e.push_back(-1);
                e.push_back(int'({4'b1010, a[10:8], 1'b1, ab}));
                e.push_back(int'({rdv, 1'b1}));
            end else begin
                e.push_back(int'({d, ab}));
            end
        end
        e.push_back(-2);
        chk({nm, " log_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk($sformatf("%s log[%0d]", nm, i), log_q[i], e[i]);
        if (!rd && acked) chk({nm, " slave_mem"}, int'(mem[a]), int'(d));
    endtask

    typedef struct {
        bit          rd;
        logic [10:0] a;
        logic [7:0]  d;
        logic [7:0]  rdv;
        int          cyc;
    } vec_t;

    vec_t v[8];

    initial begin
        int dones;
        v[0] = '{1'b0, 11'h5A3, 8'hC7, 8'h00, 464};
        v[1] = '{1'b1, 11'h5A3, 8'h00, 8'hC7, 624};
        v[2] = '{1'b0, 11'h000, 8'h00, 8'h00, 464};
        v[3] = '{1'b0, 11'h7FF, 8'hFF, 8'h00, 464};
        v[4] = '{1'b1, 11'h7FF, 8'h00, 8'hFF, 624};
        v[5] = '{1'b1, 11'h000, 8'h00, 8'h00, 624};
        v[6] = '{1'b0, 11'h123, 8'h5A, 8'h00, 464};
        v[7] = '{1'b1, 11'h123, 8'h00, 8'h5A, 624};

        reset = 1'b1; wr_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst scl", int'(scl), 1);
            chk("rst sda", int'(sda), 1);
            chk("rst busy", int'(busy), 0);
            chk("rst done", int'(done), 0);
            chk("rst rdata", int'(rdata), 0);
            chk("rst ack_err", int'(ack_err), 0);
        end
        reset = 1'b0; wr_req = 1'b0;
        @(posedge clk); #1;
        chk("post_rst idle", int'(busy), 0);

        for (int i = 0; i < 8; i++)
            txn($sformatf("vec%0d", i), v[i].rd, v[i].a, v[i].d, v[i].rdv, 1'b0, 1'b1, v[i].cyc);

        log_q.delete();
        accept_req(1'b1, 1'b1, 11'h2B4, 8'h3C);
        chk("both busy", int'(busy), 1);
        dones = 0;
        for (int c = 1; c <= 700; c++) begin
            rd_req = (c == 100);
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        rd_req = 1'b0;
        chk("both done_count", dones, 1);
        chk("both log_len", log_q.size(), 5);
        if (log_q.size() > 1) chk("both ctrl_byte", log_q[1], int'({8'hA4, 1'b0}));
        chk("both slave_mem", int'(mem[11'h2B4]), 8'h3C);
        chk("both rdata", int'(rdata), int'(exp_rd));

        accept_req(1'b0, 1'b1, 11'h0F0, 8'h11);
        repeat (232) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst scl", int'(scl), 1);
        chk("midrst sda", int'(sda), 1);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst rdata", int'(rdata), 0);
        exp_rd = 8'h00;
        txn("after_rst", 1'b0, 11'h0F0, 8'h22, 8'h00, 1'b0, 1'b1, 464);
        txn("after_rst_rd", 1'b1, 11'h0F0, 8'h00, 8'h22, 1'b0, 1'b1, 624);

        sl_en = 1'b0;
`ifdef EEPROM_I2C_ACK_CHECK_EN
        txn("nack_wr", 1'b0, 11'h100, 8'h55, 8'h00, 1'b1, 1'b0, 176);
        txn("nack_rd", 1'b1, 11'h100, 8'h00, 8'h00, 1'b1, 1'b0, 176);
`else
        txn("noack_wr", 1'b0, 11'h100, 8'h55, 8'h00, 1'b0, 1'b0, 464);
        txn("noack_rd", 1'b1, 11'h100, 8'h00, 8'hFF, 1'b0, 1'b0, 624);
`endif
        sl_en = 1'b1;
        txn("recover", 1'b0, 11'h100, 8'h66, 8'h00, 1'b0, 1'b1, 464);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
